// File: rtl/pb_debouncer_pkg.sv
// ============================================================================
// pb_debouncer_pkg : shared types and defaults for the push-button debouncer
// Revision 1.0
// ============================================================================
`default_nettype none

package pb_debouncer_pkg;

   typedef enum logic [1:0] {
      S_LOW     = 2'd0,
      S_WAIT_HI = 2'd1,
      S_HIGH    = 2'd2,
      S_WAIT_LO = 2'd3
   } ch_state_e;

   localparam int DEF_DEBOUNCE_CYCLES = 1000000;
   localparam int DEF_CNT_WIDTH       = 20;
   localparam int DEF_SYNC_STAGES     = 2;

   // Counter value at which a pending level is accepted.
   function automatic int term_count(input int cycles);
      return cycles - 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/pb_debouncer_if.sv
// ============================================================================
// pb_debouncer_if : button-side and PS-side signal bundle of the debouncer
// Revision 1.0
// ============================================================================
`default_nettype none

interface pb_debouncer_if #(
   parameter int NUM_CH = 4
);
   logic [NUM_CH-1:0] pb_raw;
   logic [NUM_CH-1:0] evt_clear;
   logic [NUM_CH-1:0] pb_level;
   logic [NUM_CH-1:0] pb_rise;
   logic [NUM_CH-1:0] pb_fall;
   logic [NUM_CH-1:0] pb_evt;

   modport master (
      output pb_raw,
      output evt_clear,
      input  pb_level,
      input  pb_rise,
      input  pb_fall,
      input  pb_evt
   );

   modport slave (
      input  pb_raw,
      input  evt_clear,
      output pb_level,
      output pb_rise,
      output pb_fall,
      output pb_evt
   );
endinterface

`default_nettype wire

// File: rtl/pb_debouncer_ch.sv
// ============================================================================
// pb_debounce_ch : one button channel - synchronizer, stability FSM, pulses
// Revision 1.0
// ============================================================================
`default_nettype none

module pb_debounce_ch
   import pb_debouncer_pkg::*;
#(
   parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int CNT_WIDTH       = DEF_CNT_WIDTH
)(
   input  logic clk,
   input  logic reset,
   input  logic raw,
   input  logic evt_clear,
   output logic level,
   output logic rise,
   output logic fall,
   output logic evt
);

   localparam logic [CNT_WIDTH-1:0] c_term_cnt = CNT_WIDTH'(term_count(DEBOUNCE_CYCLES));
   localparam logic [CNT_WIDTH-1:0] c_one      = CNT_WIDTH'(1);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   w_sync;
   ch_state_e              r_state;
   ch_state_e              w_state_nxt;
   logic [CNT_WIDTH-1:0]   r_cnt;
   logic [CNT_WIDTH-1:0]   w_cnt_nxt;
   logic                   r_level;
   logic                   r_rise;
   logic                   r_fall;
   logic                   r_evt;
   logic                   w_level_nxt;
   logic                   w_rise_nxt;
   logic                   w_fall_nxt;

   assign w_sync = r_sync[SYNC_STAGES-1];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync  <= '0;
         r_state <= S_LOW;
         r_cnt   <= '0;
         r_level <= 1'b0;
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;
         r_evt   <= 1'b0;
      end else begin
         r_sync  <= {r_sync[SYNC_STAGES-2:0], raw};
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_level <= w_level_nxt;
         r_rise  <= w_rise_nxt;
         r_fall  <= w_fall_nxt;
         // A pending rise outranks a simultaneous clear.
         r_evt   <= r_rise | (r_evt & ~evt_clear);
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = '0;
      case (r_state)
         S_LOW: begin
            if (w_sync) begin
               w_state_nxt = S_WAIT_HI;
               w_cnt_nxt   = c_one;
            end
         end
         S_WAIT_HI: begin
            if (!w_sync) begin
               w_state_nxt = S_LOW;
            end else if (r_cnt == c_term_cnt) begin
               w_state_nxt = S_HIGH;
            end else begin
               w_cnt_nxt = r_cnt + c_one;
            end
         end
         S_HIGH: begin
            if (!w_sync) begin
               w_state_nxt = S_WAIT_LO;
               w_cnt_nxt   = c_one;
            end
         end
         S_WAIT_LO: begin
            if (w_sync) begin
               w_state_nxt = S_HIGH;
            end else if (r_cnt == c_term_cnt) begin
               w_state_nxt = S_LOW;
            end else begin
               w_cnt_nxt = r_cnt + c_one;
            end
         end
         default: begin
            w_state_nxt = S_LOW;
         end
      endcase
   end

   always_comb begin
      w_level_nxt = (w_state_nxt == S_HIGH) || (w_state_nxt == S_WAIT_LO);
      w_rise_nxt  = (r_state == S_WAIT_HI) && (w_state_nxt == S_HIGH);
      w_fall_nxt  = (r_state == S_WAIT_LO) && (w_state_nxt == S_LOW);
   end

   assign level = r_level;
   assign rise  = r_rise;
   assign fall  = r_fall;
   assign evt   = r_evt;

endmodule

`default_nettype wire

// File: rtl/pb_debouncer.sv
// ============================================================================
// pb_debouncer : NUM_CH independent push-button synchronizer/debouncers
// Revision 1.0
// ============================================================================
`default_nettype none

module pb_debouncer
   import pb_debouncer_pkg::*;
#(
   parameter int NUM_CH          = 4,
   parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int CNT_WIDTH       = DEF_CNT_WIDTH
)(
   input  logic            clk,
   input  logic            reset,
   pb_debouncer_if.slave   bus
);

   logic [NUM_CH-1:0] w_level;
   logic [NUM_CH-1:0] w_rise;
   logic [NUM_CH-1:0] w_fall;
   logic [NUM_CH-1:0] w_evt;

   if ((DEBOUNCE_CYCLES < 2) ||
       (64'(DEBOUNCE_CYCLES) >= (64'd1 << CNT_WIDTH)) ||
       (SYNC_STAGES < 2) || (SYNC_STAGES > 4)) begin : g_param_err
      $fatal(1, "pb_debouncer: illegal DEBOUNCE_CYCLES/CNT_WIDTH/SYNC_STAGES");
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      pb_debounce_ch #(
         .SYNC_STAGES     (SYNC_STAGES),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CNT_WIDTH       (CNT_WIDTH)
      ) u_ch (
         .clk       (clk),
         .reset     (reset),
         .raw       (bus.pb_raw[i]),
         .evt_clear (bus.evt_clear[i]),
         .level     (w_level[i]),
         .rise      (w_rise[i]),
         .fall      (w_fall[i]),
         .evt       (w_evt[i])
      );
   end

   assign bus.pb_level = w_level;
   assign bus.pb_rise  = w_rise;
   assign bus.pb_fall  = w_fall;
   assign bus.pb_evt   = w_evt;

endmodule

`default_nettype wire
